// File: rtl/trivium_ctrl_if.sv
// Stream interface of the Trivium controller.
// Carries the key/IV input stream and the keystream output stream.
// Signal suffixes are from the controller's point of view.
interface trivium_ctrl_if;
  logic [31:0] cfg_dat_i;
  logic        cfg_vld_i;
  logic        cfg_rdy_o;
  logic [31:0] ks_dat_o;
  logic        ks_vld_o;
  logic        ks_rdy_i;

  // Controller side: consumes key/IV words and produces keystream words.
  modport slave (
    input  cfg_dat_i, cfg_vld_i, ks_rdy_i,
    output cfg_rdy_o, ks_dat_o, ks_vld_o
  );

  // Environment side: supplies key/IV words and accepts keystream words.
  modport master (
    output cfg_dat_i, cfg_vld_i, ks_rdy_i,
    input  cfg_rdy_o, ks_dat_o, ks_vld_o
  );
endinterface

// File: rtl/trivium_ctrl.sv
// Trivium sequencing front end.
// Loads key/IV words into registers A/B through one-hot strobes, then runs the
// warm-up with ce_o held high, then packs z = z_a ^ z_b ^ z_c MSB-first into
// 32-bit keystream words.  A full accumulator backs up a single output holding
// register, so bits are never lost or duplicated when the sink stalls.
module trivium_ctrl #(
  parameter int INIT_CYCLES = 1152,
  parameter int CNT_W       = 11
) (
  input  logic          clk_i,
  input  logic          n_rst_i,
  trivium_ctrl_if.slave bus,
  output logic [2:0]    ld_a_o,
  output logic [2:0]    ld_b_o,
  output logic [31:0]   ld_dat_o,
  output logic          ce_o,
  input  logic          z_a_i,
  input  logic          z_b_i,
  input  logic          z_c_i,
  output logic          init_done_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_LAST = 2'd1,
    ST_INIT = 2'd2,
    ST_KS   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [5:0]       BITS_FULL = 6'd32;

  // Load strobe for word index 0..5: low three bits go to A (key), high three to B (IV).
  function automatic logic [5:0] ld_sel(input logic [2:0] idx);
    logic [5:0] sel;
    case (idx)
      3'd0:    sel = 6'b000_001;
      3'd1:    sel = 6'b000_010;
      3'd2:    sel = 6'b000_100;
      3'd3:    sel = 6'b001_000;
      3'd4:    sel = 6'b010_000;
      3'd5:    sel = 6'b100_000;
      default: sel = 6'b000_000;
    endcase
    return sel;
  endfunction

  state_t           r_state,   w_state_nxt;
  logic [2:0]       r_idx,     w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [31:0]      r_acc,     w_acc_nxt;
  logic [5:0]       r_bits,    w_bits_nxt;
  logic             r_cfg_rdy, w_cfg_rdy_nxt;
  logic [2:0]       r_ld_a,    w_ld_a_nxt;
  logic [2:0]       r_ld_b,    w_ld_b_nxt;
  logic [31:0]      r_ld_dat,  w_ld_dat_nxt;
  logic             r_ce,      w_ce_nxt;
  logic [31:0]      r_ks_dat,  w_ks_dat_nxt;
  logic             r_ks_vld,  w_ks_vld_nxt;
  logic             r_init_done, w_init_done_nxt;

  logic        w_cfg_hs;
  logic        w_ks_drain;
  logic        w_z;
  logic [5:0]  w_sel;
  logic [31:0] w_acc_cap;
  logic [5:0]  w_bits_cap;

  assign w_cfg_hs   = bus.cfg_vld_i & r_cfg_rdy;
  assign w_ks_drain = r_ks_vld & bus.ks_rdy_i;
  assign w_z        = z_a_i ^ z_b_i ^ z_c_i;
  assign w_sel      = ld_sel(r_idx);

  // State, counters, datapath and all outputs are registered here.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state     <= ST_LOAD;
      r_idx       <= 3'd0;
      r_cnt       <= CNT_ZERO;
      r_acc       <= 32'h0000_0000;
      r_bits      <= 6'd0;
      r_cfg_rdy   <= 1'b1;
      r_ld_a      <= 3'b000;
      r_ld_b      <= 3'b000;
      r_ld_dat    <= 32'h0000_0000;
      r_ce        <= 1'b0;
      r_ks_dat    <= 32'h0000_0000;
      r_ks_vld    <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_bits      <= w_bits_nxt;
      r_cfg_rdy   <= w_cfg_rdy_nxt;
      r_ld_a      <= w_ld_a_nxt;
      r_ld_b      <= w_ld_b_nxt;
      r_ld_dat    <= w_ld_dat_nxt;
      r_ce        <= w_ce_nxt;
      r_ks_dat    <= w_ks_dat_nxt;
      r_ks_vld    <= w_ks_vld_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next-state and next-output logic; every register-next value has a default first.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_acc_nxt       = r_acc;
    w_bits_nxt      = r_bits;
    w_cfg_rdy_nxt   = 1'b0;
    w_ld_a_nxt      = 3'b000;
    w_ld_b_nxt      = 3'b000;
    w_ld_dat_nxt    = r_ld_dat;
    w_ce_nxt        = 1'b0;
    w_ks_dat_nxt    = r_ks_dat;
    w_ks_vld_nxt    = r_ks_vld & ~w_ks_drain;
    w_init_done_nxt = 1'b0;
    w_acc_cap       = r_acc;
    w_bits_cap      = r_bits;

    case (r_state)
      ST_LOAD: begin
        w_cfg_rdy_nxt = 1'b1;
        if (w_cfg_hs) begin
          w_ld_dat_nxt = bus.cfg_dat_i;
          w_ld_a_nxt   = w_sel[2:0];
          w_ld_b_nxt   = w_sel[5:3];
          if (r_idx == 3'd5) begin
            w_state_nxt   = ST_LAST;
            w_idx_nxt     = 3'd0;
            w_cfg_rdy_nxt = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end

      ST_LAST: begin
        // The final IV strobe is on the outputs now; start warm-up next cycle.
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = CNT_ZERO;
        w_ce_nxt    = 1'b1;
      end

      ST_INIT: begin
        w_ce_nxt = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt     = ST_KS;
          w_cnt_nxt       = CNT_ZERO;
          w_init_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_KS: begin
        w_init_done_nxt = 1'b1;
        // z reflects the pre-shift register state at every edge where ce_o is high.
        if (r_ce) begin
          w_acc_cap  = {r_acc[30:0], w_z};
          w_bits_cap = r_bits + 6'd1;
        end else begin
          w_acc_cap  = r_acc;
          w_bits_cap = r_bits;
        end
        w_acc_nxt = w_acc_cap;
        // A complete word moves to the holding register once it is free or draining.
        if ((w_bits_cap == BITS_FULL) && (!r_ks_vld || w_ks_drain)) begin
          w_ks_dat_nxt = w_acc_cap;
          w_ks_vld_nxt = 1'b1;
          w_bits_nxt   = 6'd0;
        end else begin
          w_bits_nxt = w_bits_cap;
        end
        w_ce_nxt = (w_bits_nxt != BITS_FULL);
      end

      default: begin
        w_state_nxt   = ST_LOAD;
        w_idx_nxt     = 3'd0;
        w_cfg_rdy_nxt = 1'b1;
      end
    endcase
  end

  assign bus.cfg_rdy_o = r_cfg_rdy;
  assign bus.ks_dat_o  = r_ks_dat;
  assign bus.ks_vld_o  = r_ks_vld;
  assign ld_a_o        = r_ld_a;
  assign ld_b_o        = r_ld_b;
  assign ld_dat_o      = r_ld_dat;
  assign ce_o          = r_ce;
  assign init_done_o   = r_init_done;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Testbench for trivium_ctrl: load-phase vector table, reset behaviour,
// warm-up/keystream timing, random z/ready streams against a bit-stream
// reference, and a full Trivium register model against a textbook golden model.
module tb_trivium_ctrl;
  localparam int INIT_CYCLES = 1152;
  localparam int NW_MAX      = 24;
  localparam int NBITS       = INIT_CYCLES + 32 * NW_MAX;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [2:0]  ld_a, ld_b;
  logic [31:0] ld_dat;
  logic        ce, init_done;
  logic        z_a = 1'b0, z_b = 1'b0, z_c = 1'b0;

  trivium_ctrl_if bus();

  trivium_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(11)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .bus(bus),
    .ld_a_o(ld_a), .ld_b_o(ld_b), .ld_dat_o(ld_dat), .ce_o(ce),
    .z_a_i(z_a), .z_b_i(z_b), .z_c_i(z_c), .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Environment: 0 = z_a tied high, 1 = random bit stream, 2 = Trivium registers
  int          env_mode = 0;
  int          ptr = 0;
  bit          stream [NBITS];
  bit          gold [32*NW_MAX];
  logic [1:93]  ra;
  logic [1:84]  rb;
  logic [1:111] rc;
  logic [31:0] last_ld = 32'h0;

  task automatic env_drive_z();
    logic b, m1, m2;
    case (env_mode)
      0: begin z_a = 1'b1; z_b = 1'b0; z_c = 1'b0; end
      1: begin
        b  = (ptr < NBITS) ? stream[ptr] : 1'b0;
        m1 = 1'($urandom_range(0, 1));
        m2 = 1'($urandom_range(0, 1));
        z_a = b ^ m1; z_b = m1 ^ m2; z_c = m2;
      end
      default: begin
        z_a = ra[66] ^ ra[93];
        z_b = rb[69] ^ rb[84];
        z_c = rc[66] ^ rc[111];
      end
    endcase
  endtask

  task automatic env_reset();
    ra = '0; rb = '0; rc = '0;
    rc[109] = 1'b1; rc[110] = 1'b1; rc[111] = 1'b1;
    ptr = 0;
    env_drive_z();
  endtask

  // Apply what the registers saw at the edge that just passed.
  task automatic env_step(input logic ce_s, input logic [2:0] la, input logic [2:0] lb,
                          input logic [31:0] d);
    logic na, nb, nc;
    if (ce_s) begin
      na = rc[66] ^ rc[111] ^ (rc[109] & rc[110]) ^ ra[69];
      nb = ra[66] ^ ra[93]  ^ (ra[91] & ra[92])   ^ rb[78];
      nc = rb[69] ^ rb[84]  ^ (rb[82] & rb[83])   ^ rc[87];
      ra = {na, ra[1:92]};
      rb = {nb, rb[1:83]};
      rc = {nc, rc[1:110]};
      ptr++;
    end else begin
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < 32; i++) begin
          if (la[j] && (32*j + i + 1) <= 80) ra[32*j + i + 1] = d[i];
          if (lb[j] && (32*j + i + 1) <= 80) rb[32*j + i + 1] = d[i];
        end
      end
    end
    env_drive_z();
  endtask

  // Textbook Trivium with key = 0, IV = 0, on one 288-bit state.
  task automatic build_gold();
    bit s [1:288];
    bit t1, t2, t3;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < INIT_CYCLES + 32*NW_MAX; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (r >= INIT_CYCLES) gold[r - INIT_CYCLES] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      case (env_mode)
        0:       r[31-i] = 1'b1;
        1:       r[31-i] = stream[INIT_CYCLES + 32*w + i];
        default: r[31-i] = gold[32*w + i];
      endcase
    end
    return r;
  endfunction

  task automatic reset_chk(input string nm);
    chk({nm, "_ctl"}, {54'h0, bus.cfg_rdy_o, ld_a, ld_b, ce, bus.ks_vld_o, init_done},
        {54'h0, 10'b1_000_000_000});
    chk({nm, "_dat"}, {bus.ks_dat_o, ld_dat}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bus.cfg_vld_i = 1'b0;
    bus.ks_rdy_i  = 1'b0;
    #1;
    reset_chk("async_reset");
    env_reset();
    last_ld = 32'h0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Load six words with random gaps (max_gap = 0 gives back-to-back).
  task automatic do_load(input logic [31:0] words [6], input int max_gap);
    int idx = 0;
    int hs_idx = -1;
    logic vld;
    logic [2:0] ea, eb;
    logic ce_s; logic [2:0] la_s, lb_s; logic [31:0] d_s;
    while (idx < 6) begin
      @(negedge clk);
      ea = 3'b000; eb = 3'b000;
      if (hs_idx >= 0 && hs_idx < 3) ea[hs_idx] = 1'b1;
      if (hs_idx >= 3) eb[hs_idx-3] = 1'b1;
      chk("load_ld_a", ld_a, ea);
      chk("load_ld_b", ld_b, eb);
      chk("load_ld_dat", ld_dat, last_ld);
      chk("load_rdy_ce", {bus.cfg_rdy_o, ce}, 2'b10);
      ce_s = ce; la_s = ld_a; lb_s = ld_b; d_s = ld_dat;
      vld = (max_gap == 0) ? 1'b1 : ($urandom_range(0, max_gap) == 0);
      bus.cfg_vld_i = vld;
      bus.cfg_dat_i = vld ? words[idx] : $urandom;
      if (vld) begin
        hs_idx = idx; last_ld = words[idx]; idx++;
      end else begin
        hs_idx = -1;
      end
      @(posedge clk); #1;
      env_step(ce_s, la_s, lb_s, d_s);
    end
    // Anything offered after the sixth word must be ignored.
    bus.cfg_vld_i = 1'b1;
    bus.cfg_dat_i = 32'hBAD0_BAD0;
  endtask

  // Runs from the cycle after the sixth handshake (e = 0 is the LAST cycle).
  task automatic run_ks(input int rdy_mode, input int n_words, input int stall_ks);
    int e = 0, got = 0, ce_init = 0, ce_ks = 0, overlap = 0;
    int first_done = -1, first_vld = -1, last_hs_e = -1, stall_left = 0, ks_cyc;
    logic vld_prev = 1'b0, rdy_prev = 1'b0, rdy;
    logic [31:0] dat_prev = 32'h0;
    logic ce_s; logic [2:0] la_s, lb_s; logic [31:0] d_s;
    while (got < n_words && e < 1300 + n_words*400) begin
      @(negedge clk);
      ce_s = ce; la_s = ld_a; lb_s = ld_b; d_s = ld_dat;
      if (ce_s && (ld_a != 3'b000 || ld_b != 3'b000)) overlap++;
      if (ce_s && !init_done) ce_init++;
      if (ce_s && init_done) ce_ks++;
      if (init_done && first_done < 0) first_done = e;
      if (bus.ks_vld_o && first_vld < 0) first_vld = e;
      ks_cyc = (first_done < 0) ? -1 : e - first_done;
      if (e == 0) begin
        chk("last_ld_b", ld_b, 3'b100);
        chk("last_rdy_ce", {bus.cfg_rdy_o, ce}, 2'b00);
      end
      if (e == 1) chk("init_no_strobe", {bus.cfg_rdy_o, ld_a, ld_b}, 7'b0);
      if (vld_prev && !rdy_prev) begin
        chk("stall_dat_stable", bus.ks_dat_o, dat_prev);
        chk("stall_vld_held", bus.ks_vld_o, 1'b1);
      end
      case (rdy_mode)
        1: begin
          if (stall_left > 0) begin
            rdy = 1'b0; stall_left--;
          end else if ($urandom_range(0, 39) == 0) begin
            stall_left = $urandom_range(20, 100); rdy = 1'b0;
          end else begin
            rdy = ($urandom_range(0, 1) == 1);
          end
        end
        2: rdy = (ks_cyc >= stall_ks);
        default: rdy = 1'b1;
      endcase
      if (rdy_mode == 2 && ks_cyc == stall_ks) begin
        chk("stall_bits_taken", ce_ks, 64);
        chk("stall_ce_low", ce_s, 1'b0);
      end
      bus.ks_rdy_i = rdy;
      if (bus.ks_vld_o && rdy) begin
        chk($sformatf("ks_word%0d", got), bus.ks_dat_o, exp_word(got));
        if (rdy_mode == 0 && got > 0) chk("ks_period", e - last_hs_e, 32);
        last_hs_e = e;
        got++;
      end
      vld_prev = bus.ks_vld_o; rdy_prev = rdy; dat_prev = bus.ks_dat_o;
      @(posedge clk); #1;
      env_step(ce_s, la_s, lb_s, d_s);
      e++;
    end
    if (got < n_words) chk("ks_timeout_words", got, n_words);
    chk("init_ce_count", ce_init, INIT_CYCLES);
    chk("ce_ld_overlap", overlap, 0);
    chk("first_init_done", first_done, INIT_CYCLES + 1);
    chk("first_ks_vld", first_vld, INIT_CYCLES + 33);
    chk("cfg_ignored_ld_dat", ld_dat, last_ld);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic [2:0]  la;
    logic [2:0]  lb;
    logic [31:0] ld;
    logic        ce;
  } vec_t;

  vec_t tbl [14];
  logic [31:0] words [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            vld   dat            rdy   ld_a    ld_b    ld_dat         ce
    tbl[0]  = '{1'b0, 32'h0000_0000, 1'b1, 3'b000, 3'b000, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0000, 1'b1, 3'b001, 3'b000, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'hDEAD_BEEF, 1'b1, 3'b000, 3'b000, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b0, 32'hDEAD_BEEF, 1'b1, 3'b000, 3'b000, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h1111_1111, 1'b1, 3'b010, 3'b000, 32'h1111_1111, 1'b0};
    tbl[5]  = '{1'b0, 32'h0BAD_0BAD, 1'b1, 3'b000, 3'b000, 32'h1111_1111, 1'b0};
    tbl[6]  = '{1'b1, 32'h2222_2222, 1'b1, 3'b100, 3'b000, 32'h2222_2222, 1'b0};
    tbl[7]  = '{1'b1, 32'h3333_3333, 1'b1, 3'b000, 3'b001, 32'h3333_3333, 1'b0};
    tbl[8]  = '{1'b0, 32'h0BAD_0BAD, 1'b1, 3'b000, 3'b000, 32'h3333_3333, 1'b0};
    tbl[9]  = '{1'b0, 32'h0BAD_0BAD, 1'b1, 3'b000, 3'b000, 32'h3333_3333, 1'b0};
    tbl[10] = '{1'b1, 32'h4444_4444, 1'b1, 3'b000, 3'b010, 32'h4444_4444, 1'b0};
    tbl[11] = '{1'b1, 32'h5555_5555, 1'b0, 3'b000, 3'b100, 32'h5555_5555, 1'b0};
    tbl[12] = '{1'b1, 32'h6666_6666, 1'b0, 3'b000, 3'b000, 32'h5555_5555, 1'b1};
    tbl[13] = '{1'b0, 32'h7777_7777, 1'b0, 3'b000, 3'b000, 32'h5555_5555, 1'b1};

    bus.cfg_vld_i = 1'b0;
    bus.cfg_dat_i = 32'h0;
    bus.ks_rdy_i  = 1'b0;
    env_mode = 0;
    env_reset();
    build_gold();

    // Reset release and 100 idle cycles
    repeat (2) @(negedge clk);
    #1;
    reset_chk("in_reset");
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      reset_chk("idle");
    end

    // Load-phase vector table, including gaps and the hand-off into warm-up
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.cfg_vld_i = tbl[i].vld;
      bus.cfg_dat_i = tbl[i].dat;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rdy", i), bus.cfg_rdy_o, tbl[i].rdy);
      chk($sformatf("tbl%0d_ld_a", i), ld_a, tbl[i].la);
      chk($sformatf("tbl%0d_ld_b", i), ld_b, tbl[i].lb);
      chk($sformatf("tbl%0d_ld_dat", i), ld_dat, tbl[i].ld);
      chk($sformatf("tbl%0d_ce", i), ce, tbl[i].ce);
    end

    // Reset in the middle of warm-up (INIT cycle 500)
    bus.cfg_vld_i = 1'b0;
    repeat (498) @(negedge clk);
    chk("mid_init_ce_done", {ce, init_done}, 2'b10);
    do_reset();

    // Back-to-back words 0..5, z_a tied high, sink always ready
    env_mode = 0;
    env_reset();
    for (int i = 0; i < 6; i++) words[i] = i;
    do_load(words, 0);
    run_ks(0, 5, 0);

    // Random key/IV words with gaps, random z split, bursty sink
    do_reset();
    env_mode = 1;
    for (int i = 0; i < NBITS; i++) stream[i] = 1'($urandom_range(0, 1));
    env_reset();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    do_load(words, 3);
    run_ks(1, 20, 0);

    // Full system with Trivium registers, key = IV = 0, sink stalled 200 KS cycles
    do_reset();
    env_mode = 2;
    env_reset();
    for (int i = 0; i < 6; i++) words[i] = 32'h0;
    do_load(words, 1);
    run_ks(2, 6, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
